// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the serial instruction loader.
// The stream source uses the master side and the loader uses the slave side.
interface imem_loader_if;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        WrEn;
    logic [31:0] WrAddr;
    logic [31:0] WrData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic        CpuHold;

    modport master (
        output Start, ByteIn, ByteValid,
        input  ByteReady, WrEn, WrAddr, WrData, Busy, Done, Error, CpuHold
    );

    modport slave (
        input  Start, ByteIn, ByteValid,
        output ByteReady, WrEn, WrAddr, WrData, Busy, Done, Error, CpuHold
    );
endinterface

// File: rtl/imem_loader.sv
// Serial instruction loader: parses a length-prefixed, checksummed byte stream into
// big-endian words written to instruction memory, holding the CPU until a good load.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int unsigned MAX_WORDS = 192
) (
    input  logic          Clk,
    input  logic          Rst_n,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [15:0] MAX_WORDS_W = 16'(MAX_WORDS);

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        csum_add = acc + b;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  csum_q, csum_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        byte_ready_q, byte_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        cpu_hold_q, cpu_hold_d;

    logic        accept_s;
    logic        start_s;
    logic [15:0] len_s;
    logic        last_word_s;

    assign accept_s    = bus.ByteValid & byte_ready_q;
    assign start_s     = bus.Start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
    assign len_s       = {len_q[15:8], bus.ByteIn};
    assign last_word_s = (byte_cnt_q == 2'd3) & (word_idx_q == (len_q - 16'd1));

    // State and datapath registers; reset drops any partial word and parks in IDLE.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            len_q        <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            csum_q       <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= 32'd0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    // Next-state logic; Start is only honoured outside an active session.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.Start) state_d = LEN_HI;
                else           state_d = state_q;
            end
            LEN_HI: begin
                if (accept_s) state_d = LEN_LO;
                else          state_d = LEN_HI;
            end
            LEN_LO: begin
                if (!accept_s)                state_d = LEN_LO;
                else if (len_s == 16'd0)      state_d = CHECK;
                else if (len_s > MAX_WORDS_W) state_d = ERR;
                else                          state_d = DATA;
            end
            DATA: begin
                if (accept_s && last_word_s) state_d = CHECK;
                else                         state_d = DATA;
            end
            CHECK: begin
                if (!accept_s)                  state_d = CHECK;
                else if (bus.ByteIn == csum_q)  state_d = DONE;
                else                            state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and status; status flops follow state_d so they line up with state_q.
    always_comb begin
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (start_s) begin
            word_idx_d = 16'd0;
            byte_cnt_d = 2'd0;
            csum_d     = 8'd0;
        end else if (accept_s) begin
            case (state_q)
                LEN_HI: len_d = {bus.ByteIn, 8'h00};
                LEN_LO: len_d = len_s;
                DATA: begin
                    csum_d     = csum_add(csum_q, bus.ByteIn);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], bus.ByteIn};
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        wr_data_d  = {shift_q, bus.ByteIn};
                        word_idx_d = word_idx_q + 16'd1;
                    end else begin
                        wr_en_d    = 1'b0;
                    end
                end
                default: len_d = len_q;
            endcase
        end else begin
            len_d = len_q;
        end

        byte_ready_d = (state_d == LEN_HI) | (state_d == LEN_LO) |
                       (state_d == DATA)   | (state_d == CHECK);
        busy_d       = byte_ready_d;
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
        cpu_hold_d   = (state_d != DONE);
    end

    assign bus.ByteReady = byte_ready_q;
    assign bus.Busy      = busy_q;
    assign bus.WrEn      = wr_en_q;
    assign bus.WrAddr    = wr_addr_q;
    assign bus.WrData    = wr_data_q;
    assign bus.Done      = done_q;
    assign bus.Error     = error_q;
    assign bus.CpuHold   = cpu_hold_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0100, byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 192, the largest legal word count (0x100..0x3FC).
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  begins a load session; sampled every cycle.
REQ-006 SHALL have port ByteIn  input  8  serial stream byte.
REQ-007 SHALL have port ByteValid  input  1  ByteIn is valid.
REQ-008 SHALL have port ByteReady  output  1  loader can accept a byte.
REQ-009 SHALL have port WrEn  output  1  one-cycle instruction-memory write strobe.
REQ-010 SHALL have port WrAddr  output  32  word-aligned write byte address.
REQ-011 SHALL have port WrData  output  32  assembled instruction word.
REQ-012 SHALL have port Busy  output  1  session in progress.
REQ-013 SHALL have port Done  output  1  last session completed with a good checksum.
REQ-014 SHALL have port Error  output  1  last session failed.
REQ-015 SHALL have port CpuHold  output  1  holds the CPU stalled while high.

Function
REQ-016 Stream format SHALL be: LEN_HI byte, LEN_LO byte (16-bit word count N, big-endian), 4*N payload bytes, then 1 checksum byte.
REQ-017 A byte SHALL be accepted on a rising edge where ByteValid and ByteReady are both 1; ByteIn at other times SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
REQ-019 ByteReady SHALL be 1 exactly in LEN_HI, LEN_LO, DATA and CHECK; Busy SHALL be 1 in the same states.
REQ-020 Start in IDLE, DONE or ERR SHALL move to LEN_HI, clearing Done, Error, word index and checksum; Start in any Busy state SHALL be ignored.
REQ-021 LEN_HI accept -> LEN_LO; LEN_LO accept -> CHECK if N==0, ERR if N>MAX_WORDS, else DATA.
REQ-022 Payload words SHALL assemble big-endian: first byte of each group to bits [31:24], fourth to [7:0].
REQ-023 The cycle after the 4th byte of word k (k from 0) is accepted, WrEn SHALL be 1 for exactly one cycle, with WrAddr=BASE_ADDR+4*k and WrData equal to the assembled word.
REQ-024 Byte acceptance SHALL continue without stall while the WrEn pulse is issued, so back-to-back bytes are never refused in DATA.
REQ-025 After word N-1 is accepted, the FSM SHALL go to CHECK.
REQ-026 Checksum SHALL be the 8-bit sum, wrapping mod 256, of all payload bytes; length and checksum bytes SHALL be excluded.
REQ-027 CHECK accept SHALL go to DONE if the byte equals the checksum, else to ERR.
REQ-028 In DONE: Done=1 and CpuHold=0. In ERR: Error=1 and CpuHold=1. Both SHALL be held until Start or reset.
REQ-029 CpuHold SHALL be 1 in all states except DONE.
REQ-030 Words already written before an ERR SHALL NOT be retracted; no WrEn SHALL occur outside DATA-derived pulses.

Reset
REQ-031 Rst_n low SHALL immediately force IDLE with ByteReady=0, WrEn=0, WrAddr=BASE_ADDR, WrData=0, Busy=0, Done=0, Error=0, CpuHold=1.
REQ-032 Reset mid-session SHALL discard any partial word with no WrEn, and SHALL clear the index and checksum.
REQ-033 After Rst_n deasserts, the loader SHALL remain in IDLE until Start is seen.

Verification
REQ-034 Start; bytes 00 02 20 02 01 40 00 00 00 0C 6F -> WrEn (0x100, 0x2002_0140), then WrEn (0x104, 0x0000_000C); Done=1, CpuHold=0.
REQ-035 Same stream with checksum 0x70 -> both writes occur, then Error=1, Done=0, CpuHold=1.
REQ-036 Start; bytes 00 00 00 -> no WrEn, Done=1. Start; bytes 00 C1 -> Error=1 after LEN_LO, ByteReady=0, no WrEn.
REQ-037 REQ-034 stream with ByteValid randomly deasserted between bytes, and Start pulsed mid-DATA -> results identical to REQ-034.
REQ-038 Rst_n low after 2 payload bytes -> all outputs at reset values, no WrEn; then Start plus the full REQ-034 stream -> Done=1.
REQ-039 N=192 of incrementing words -> last WrEn at 0x3FC, Done=1 with correct checksum.
